// File: rtl/key_pkg.sv
// Shared definitions for the key pulse conditioner: state encoding, code width
// and the default debounce interval for a 50 MHz board clock.
package key_pkg;

    localparam logic [1:0] ARMED = 2'd0;
    localparam logic [1:0] QUAL  = 2'd1;
    localparam logic [1:0] HELD  = 2'd2;
    localparam logic [1:0] REL   = 2'd3;

    typedef enum logic [1:0] {
        ST_ARMED = ARMED,
        ST_QUAL  = QUAL,
        ST_HELD  = HELD,
        ST_REL   = REL
    } key_state_e;

    localparam int KEY_CODE_W = 4;

    // 10 ms of stability at 50 MHz
    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

endpackage

// File: rtl/key_pulse_conditioner_sync2.sv
// Two-flop synchroniser for asynchronous level inputs, any width.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    // metastability filter: two back-to-back stages
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/key_pulse_conditioner.sv
// Debounces the key/switch bank and emits one single-cycle one-hot pulse per
// accepted press, or an error pulse when several keys qualify together.
module key_pulse_conditioner
    import key_pkg::*;
#(
    parameter int N_KEYS          = 10,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_KEYS-1:0]     sw,
    output logic [N_KEYS-1:0]     key_pulse,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_err,
    output logic                  busy
);

    localparam int                OW       = $clog2(N_KEYS + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_KEYS-1:0]     s2;
    key_state_e            state_q;
    logic [N_KEYS-1:0]     sample_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [N_KEYS-1:0]     key_pulse_q;
    logic [KEY_CODE_W-1:0] key_code_q;
    logic                  key_err_q;
    logic                  busy_q;
    logic [OW-1:0]         sample_ones;
    logic [KEY_CODE_W-1:0] sample_code;
    logic                  sample_onehot;

    sync2 #(
        .WIDTH (N_KEYS)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (sw),
        .q_o (s2)
    );

    // popcount and priority encoder over the captured pattern
    always_comb begin
        sample_ones = '0;
        sample_code = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            sample_ones = sample_ones + {{(OW-1){1'b0}}, sample_q[i]};
            if (sample_q[i]) begin
                sample_code = KEY_CODE_W'(i);
            end else begin
                sample_code = sample_code;
            end
        end
        sample_onehot = (sample_ones == OW'(1));
    end

    // press/release qualification FSM with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_HELD;
            sample_q    <= '0;
            cnt_q       <= '0;
            key_pulse_q <= '0;
            key_code_q  <= '0;
            key_err_q   <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            key_pulse_q <= '0;
            key_code_q  <= '0;
            key_err_q   <= 1'b0;
            case (state_q)
                ST_ARMED: begin
                    if (s2 == '0) begin
                        busy_q <= 1'b0;
                    end else begin
                        sample_q <= s2;
                        cnt_q    <= '0;
                        state_q  <= ST_QUAL;
                        busy_q   <= 1'b1;
                    end
                end
                ST_QUAL: begin
                    if (s2 == '0) begin
                        state_q <= ST_ARMED;
                        busy_q  <= 1'b0;
                    end else if (s2 != sample_q) begin
                        sample_q <= s2;
                        cnt_q    <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        if (sample_onehot) begin
                            key_pulse_q <= sample_q;
                            key_code_q  <= sample_code;
                        end else begin
                            key_err_q <= 1'b1;
                        end
                        state_q <= ST_HELD;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_HELD: begin
                    // keys added while held are deliberately ignored
                    if (s2 == '0) begin
                        cnt_q   <= '0;
                        state_q <= ST_REL;
                    end else begin
                        state_q <= ST_HELD;
                    end
                end
                ST_REL: begin
                    if (s2 != '0) begin
                        state_q <= ST_HELD;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= ST_ARMED;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_HELD;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign key_pulse = key_pulse_q;
    assign key_code  = key_code_q;
    assign key_err   = key_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_key_pulse_conditioner.sv
// Randomised bench for key_pulse_conditioner against a run-length model of
// press/release qualification, with one task per scenario.
module tb_key_pulse_conditioner;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] sw  = '0;
    logic [9:0] key_pulse;
    logic [3:0] key_code;
    logic       key_err;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    // model state: synchroniser pipeline plus run lengths of observed patterns
    logic [9:0] m_s1, m_s2, m_last;
    bit         m_armed;
    int         m_run, m_zrun;
    logic [9:0] exp_pulse;
    logic [3:0] exp_code;
    logic       exp_err, exp_busy;

    int         edge_no = 0;
    int         trace_bad = 0, bad_edge = 0, overlap = 0, obs_err = 0;
    logic [9:0] bad_dut, bad_exp;
    logic [9:0] obs_val[$], exp_val[$];
    logic [3:0] obs_code[$];
    int         obs_edge[$];

    key_pulse_conditioner #(
        .N_KEYS          (10),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .key_pulse (key_pulse),
        .key_code  (key_code),
        .key_err   (key_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_last = '0;
        m_armed = 1'b0; m_run = 0; m_zrun = 0;
        exp_pulse = '0; exp_code = '0; exp_err = 1'b0; exp_busy = 1'b1;
    endtask

    task automatic model_edge();
        logic [9:0] v;
        if (!rst) begin
            model_reset();
        end else begin
            v = m_s2; m_s2 = m_s1; m_s1 = sw;
            exp_pulse = '0; exp_code = '0; exp_err = 1'b0;
            if (!m_armed) begin
                m_zrun = (v == '0) ? m_zrun + 1 : 0;
                if (m_zrun == D + 1) begin m_armed = 1'b1; m_run = 0; end
            end else begin
                if (v == '0) m_run = 0;
                else if (m_run > 0 && v == m_last) m_run++;
                else begin m_run = 1; m_last = v; end
                if (m_run == D + 1) begin
                    if ($countones(v) == 1) begin
                        exp_pulse = v;
                        exp_code  = 4'($clog2(v));
                        exp_val.push_back(v);
                    end else begin
                        exp_err = 1'b1;
                    end
                    m_armed = 1'b0; m_zrun = 0; m_run = 0;
                end
            end
            exp_busy = !(m_armed && m_run == 0);
        end
    endtask

    task automatic clear_logs();
        trace_bad = 0; overlap = 0; obs_err = 0;
        obs_val.delete(); obs_code.delete(); obs_edge.delete(); exp_val.delete();
    endtask

    // drive one input value over one clock edge and record what was seen
    task automatic step(input logic [9:0] v_sw);
        sw = v_sw;
        @(posedge clk);
        edge_no++;
        model_edge();
        #1;
        if (key_pulse !== '0) begin
            obs_val.push_back(key_pulse); obs_code.push_back(key_code); obs_edge.push_back(edge_no);
        end
        if (key_err === 1'b1) obs_err++;
        if (key_err === 1'b1 && key_pulse !== '0) overlap++;
        if (key_pulse !== exp_pulse || key_code !== exp_code ||
            key_err !== exp_err || busy !== exp_busy) begin
            if (trace_bad == 0) begin bad_edge = edge_no; bad_dut = key_pulse; bad_exp = exp_pulse; end
            trace_bad++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0);
    endtask

    task automatic test_reset();
        rst = 1'b1; sw = '0;
        #2 rst = 1'b0;
        model_reset();
        #1;
        checks++; if (key_pulse !== 10'h000) begin failures++; $display("FAIL reset_pulse got=%h exp=000", key_pulse); end
        checks++; if (key_code !== 4'd0) begin failures++; $display("FAIL reset_code got=%0d exp=0", key_code); end
        checks++; if (key_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", key_err); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", busy); end
        step('0); step('0);
        rst = 1'b1;
        clear_logs();
        idle(10);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_armed busy got=%b exp=0", busy); end
        checks++; if (trace_bad !== 0) begin failures++; $display("FAIL reset_trace bad=%0d edge=%0d", trace_bad, bad_edge); end
    endtask

    task automatic test_single_press();
        int press_edge;
        idle(8); clear_logs();
        press_edge = edge_no + 1;
        for (int i = 0; i < 20; i++) step(10'h200);
        idle(10);
        checks++; if (obs_val.size() !== 1) begin failures++; $display("FAIL single_count got=%0d exp=1", obs_val.size()); end
        if (obs_val.size() > 0) begin
            checks++; if (obs_val[0] !== 10'h200) begin failures++; $display("FAIL single_value got=%h exp=200", obs_val[0]); end
            checks++; if (obs_code[0] !== 4'd9) begin failures++; $display("FAIL single_code got=%0d exp=9", obs_code[0]); end
            checks++; if (obs_edge[0] - press_edge !== 6) begin failures++; $display("FAIL single_latency got=%0d exp=6", obs_edge[0] - press_edge); end
        end
        checks++; if (obs_err !== 0) begin failures++; $display("FAIL single_err got=%0d exp=0", obs_err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%b exp=0", busy); end
        checks++; if (trace_bad !== 0) begin failures++; $display("FAIL single_trace bad=%0d edge=%0d dut=%h exp=%h", trace_bad, bad_edge, bad_dut, bad_exp); end
    endtask

    task automatic test_bounce();
        idle(12); clear_logs();
        for (int i = 0; i < 12; i++) begin
            int on_c  = $urandom_range(1, 3);
            int off_c = $urandom_range(1, 3);
            for (int j = 0; j < on_c; j++) step(10'h100);
            for (int j = 0; j < off_c; j++) step('0);
        end
        idle(8);
        checks++; if (obs_val.size() !== 0) begin failures++; $display("FAIL bounce_count got=%0d exp=0", obs_val.size()); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bounce_armed busy got=%b exp=0", busy); end
        checks++; if (trace_bad !== 0) begin failures++; $display("FAIL bounce_trace bad=%0d edge=%0d", trace_bad, bad_edge); end
    endtask

    task automatic test_multi_key();
        idle(12); clear_logs();
        for (int i = 0; i < 12; i++) step(10'h180);
        idle(12);
        checks++; if (obs_err !== 1) begin failures++; $display("FAIL multi_err got=%0d exp=1", obs_err); end
        checks++; if (obs_val.size() !== 0) begin failures++; $display("FAIL multi_pulse got=%0d exp=0", obs_val.size()); end
        checks++; if (overlap !== 0) begin failures++; $display("FAIL multi_overlap got=%0d exp=0", overlap); end
        checks++; if (trace_bad !== 0) begin failures++; $display("FAIL multi_trace bad=%0d edge=%0d", trace_bad, bad_edge); end
    endtask

    task automatic test_add_while_held();
        idle(12); clear_logs();
        for (int i = 0; i < 8; i++) step(10'h200);
        for (int i = 0; i < 10; i++) step(10'h240);
        idle(12);
        checks++; if (obs_val.size() !== 1) begin failures++; $display("FAIL held_count got=%0d exp=1", obs_val.size()); end
        if (obs_val.size() > 0) begin
            checks++; if (obs_val[0] !== 10'h200) begin failures++; $display("FAIL held_value got=%h exp=200", obs_val[0]); end
        end
        checks++; if (trace_bad !== 0) begin failures++; $display("FAIL held_trace bad=%0d edge=%0d", trace_bad, bad_edge); end
    endtask

    task automatic test_back_to_back();
        logic [9:0] k;
        idle(12); clear_logs();
        for (int i = 0; i < 4; i++) begin
            k = 10'h200 >> i;
            for (int j = 0; j < 8; j++) step(k);
            idle(10);
        end
        checks++; if (obs_val.size() !== 4) begin failures++; $display("FAIL seq_count got=%0d exp=4", obs_val.size()); end
        for (int i = 0; i < 4 && i < obs_val.size(); i++) begin
            k = 10'h200 >> i;
            checks++; if (obs_val[i] !== k) begin failures++; $display("FAIL seq_value[%0d] got=%h exp=%h", i, obs_val[i], k); end
            checks++; if (obs_code[i] !== 4'(9 - i)) begin failures++; $display("FAIL seq_code[%0d] got=%0d exp=%0d", i, obs_code[i], 9 - i); end
        end
        checks++; if (trace_bad !== 0) begin failures++; $display("FAIL seq_trace bad=%0d edge=%0d", trace_bad, bad_edge); end
    endtask

    task automatic test_random();
        logic [9:0] p;
        idle(12); clear_logs();
        for (int i = 0; i < 30; i++) begin
            p = 10'h001 << $urandom_range(0, 9);
            if ($urandom_range(0, 3) == 0) p = p | (10'h001 << $urandom_range(0, 9));
            for (int j = 0, n = $urandom_range(1, 9); j < n; j++) step(p);
            for (int j = 0, n = $urandom_range(1, 10); j < n; j++) step('0);
        end
        idle(12);
        checks++; if (obs_val.size() !== exp_val.size()) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", obs_val.size(), exp_val.size()); end
        for (int i = 0; i < obs_val.size() && i < exp_val.size(); i++) begin
            checks++; if (obs_val[i] !== exp_val[i]) begin failures++; $display("FAIL rand_value[%0d] got=%h exp=%h", i, obs_val[i], exp_val[i]); end
        end
        checks++; if (overlap !== 0) begin failures++; $display("FAIL rand_overlap got=%0d exp=0", overlap); end
        checks++; if (trace_bad !== 0) begin failures++; $display("FAIL rand_trace bad=%0d edge=%0d dut=%h exp=%h", trace_bad, bad_edge, bad_dut, bad_exp); end
    endtask

    task automatic test_reset_while_held();
        bit found;
        idle(12); clear_logs();
        for (int i = 0; i < 10; i++) step(10'h001);
        rst = 1'b0;
        model_reset();
        #1;
        checks++; if (key_pulse !== 10'h000 || key_err !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL mid_reset got=%h/%b/%b exp=000/0/1", key_pulse, key_err, busy); end
        step(10'h001); step(10'h001);
        rst = 1'b1;
        clear_logs();
        for (int i = 0; i < 20; i++) step(10'h001);
        checks++; if (obs_val.size() !== 0) begin failures++; $display("FAIL held_through_reset got=%0d exp=0", obs_val.size()); end
        idle(10);
        found = 1'b0;
        for (int i = 0; i < 15 && !found; i++) begin
            step(10'h001);
            if (key_pulse !== '0) found = 1'b1;
        end
        checks++; if (!found) begin failures++; $display("FAIL repress_pulse got=none exp=001"); end
        checks++; if (trace_bad !== 0) begin failures++; $display("FAIL repress_trace bad=%0d edge=%0d", trace_bad, bad_edge); end
        rst = 1'b0;
        model_reset();
        #1;
        checks++; if (key_pulse !== 10'h000) begin failures++; $display("FAIL pulse_reset_pulse got=%h exp=000", key_pulse); end
        checks++; if (key_code !== 4'd0) begin failures++; $display("FAIL pulse_reset_code got=%0d exp=0", key_code); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL pulse_reset_busy got=%b exp=1", busy); end
        step('0); step('0);
        rst = 1'b1;
        clear_logs();
        idle(10);
        checks++; if (trace_bad !== 0) begin failures++; $display("FAIL post_reset_trace bad=%0d edge=%0d", trace_bad, bad_edge); end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_multi_key();
        test_add_while_held();
        test_back_to_back();
        test_random();
        test_reset_while_held();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
